i2s_transmitter: RTL and testbench

Serializes parallel stereo audio samples into an I2S bit stream for the DAC. It sits at the output end of the audio path, after the distortion and effects stage, and consumes that stage's `tx_data`-style samples. The block takes left/right sample pairs through a one-deep valid/ready buffer. It generates SCLK and LRCK from the system clock and shifts each sample out MSB-first in standard I2S format, with the MSB one SCLK after the LRCK edge.

---
 rtl/i2s_transmitter_if.sv | 24 ++
 rtl/i2s_transmitter.sv | 112 +++++++++++
 tb/tb_i2s_transmitter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_transmitter_if.sv
// Sample-pair handshake between the effects stage and the I2S transmitter.
// The source drives data/valid; the transmitter answers with ready.
interface i2s_transmitter_if #(
   parameter int DATA_WIDTH = 24
);
   logic [DATA_WIDTH-1:0] tx_data_l;
   logic [DATA_WIDTH-1:0] tx_data_r;
   logic                  tx_valid;
   logic                  tx_ready;

   modport master (
      output tx_data_l,
      output tx_data_r,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data_l,
      input  tx_data_r,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/i2s_transmitter.sv
// Stereo I2S serializer: one-deep pair buffer, SCLK/LRCK generation,
// MSB-first data delayed one SCLK after each LRCK edge.
module i2s_transmitter #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_BITS  = 32,
   parameter int SCLK_RATIO = 4
) (
   input  logic             clk,
   input  logic             reset,
   i2s_transmitter_if.slave tx,
   output logic             sclk,
   output logic             lrck,
   output logic             sdata,
   output logic             underrun
);
   localparam int DW_D = $clog2(SCLK_RATIO);
   localparam int DW_P = $clog2(2 * SLOT_BITS);

   localparam logic [DW_D-1:0] DIV_LAST = DW_D'(SCLK_RATIO - 1);
   localparam logic [DW_D-1:0] DIV_HALF = DW_D'(SCLK_RATIO / 2);
   localparam logic [DW_P-1:0] POS_LAST = DW_P'(2 * SLOT_BITS - 1);
   localparam logic [DW_P-1:0] POS_ONE  = DW_P'(1);
   localparam logic [DW_P-1:0] POS_LDW  = DW_P'(DATA_WIDTH);
   localparam logic [DW_P-1:0] POS_SLOT = DW_P'(SLOT_BITS);
   localparam logic [DW_P-1:0] POS_R1   = DW_P'(SLOT_BITS + 1);
   localparam logic [DW_P-1:0] POS_RDW  = DW_P'(SLOT_BITS + DATA_WIDTH);

   logic [DW_D-1:0]       r_div;
   logic [DW_P-1:0]       r_pos;
   logic [DATA_WIDTH-1:0] r_hold_l;
   logic [DATA_WIDTH-1:0] r_hold_r;
   logic                  r_full;
   logic [DATA_WIDTH-1:0] r_sh_l;
   logic [DATA_WIDTH-1:0] r_sh_r;
   logic                  r_sclk;
   logic                  r_lrck;
   logic                  r_sdata;
   logic                  r_underrun;

   logic            w_div_wrap;
   logic            w_load;
   logic            w_accept;
   logic [DW_D-1:0] w_div_nxt;
   logic [DW_P-1:0] w_pos_nxt;

   assign w_div_wrap = (r_div == DIV_LAST);
   assign w_load     = w_div_wrap && (r_pos == POS_LAST);
   assign w_div_nxt  = w_div_wrap ? '0 : r_div + 1'b1;
   assign w_accept   = tx.tx_valid && tx.tx_ready;

   always_comb begin
      w_pos_nxt = r_pos;
      if (w_div_wrap) begin
         w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
      end
   end

   assign tx.tx_ready = !r_full && !reset;

   // Outputs are computed from the next counter state so they stay
   // aligned with the div/pos value they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div      <= '0;
         r_pos      <= '0;
         r_hold_l   <= '0;
         r_hold_r   <= '0;
         r_full     <= 1'b0;
         r_sh_l     <= '0;
         r_sh_r     <= '0;
         r_sclk     <= 1'b0;
         r_lrck     <= 1'b0;
         r_sdata    <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_div      <= w_div_nxt;
         r_pos      <= w_pos_nxt;
         r_sclk     <= (w_div_nxt >= DIV_HALF);
         r_underrun <= w_load && !r_full;

         if (w_accept) begin
            r_hold_l <= tx.tx_data_l;
            r_hold_r <= tx.tx_data_r;
         end
         r_full <= w_load ? w_accept : (r_full || w_accept);

         if (w_div_wrap) begin
            r_lrck <= (w_pos_nxt >= POS_SLOT);
            if (w_pos_nxt >= POS_ONE && w_pos_nxt <= POS_LDW) begin
               r_sdata <= r_sh_l[DATA_WIDTH-1];
               r_sh_l  <= r_sh_l << 1;
            end else if (w_pos_nxt >= POS_R1 && w_pos_nxt <= POS_RDW) begin
               r_sdata <= r_sh_r[DATA_WIDTH-1];
               r_sh_r  <= r_sh_r << 1;
            end else begin
               r_sdata <= 1'b0;
            end
         end

         // An empty buffer at frame load sends a silent frame.
         if (w_load) begin
            r_sh_l <= r_full ? r_hold_l : '0;
            r_sh_r <= r_full ? r_hold_r : '0;
         end
      end
   end

   assign sclk     = r_sclk;
   assign lrck     = r_lrck;
   assign sdata    = r_sdata;
   assign underrun = r_underrun;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: reset, single pair, underrun,
// streaming, clock shape and mid-frame reset.
module tb_i2s_transmitter;
   localparam int DW = 24;
   localparam int FRAME = 256;

   typedef struct {
      int   p;
      logic sd;
      logic lr;
   } vec_t;

   logic clk;
   logic reset;
   logic sclk, lrck, sdata, underrun;

   i2s_transmitter_if #(.DATA_WIDTH(DW)) bus ();

   i2s_transmitter #(
      .DATA_WIDTH(DW),
      .SLOT_BITS (32),
      .SCLK_RATIO(4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .tx      (bus.slave),
      .sclk    (sclk),
      .lrck    (lrck),
      .sdata   (sdata),
      .underrun(underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int t = 0;
   int ur_cnt = 0;
   int ur_t = -1;
   int acc_cnt = 0;
   int stream_on = 0;
   int next_val = 0;
   logic [1:0] prev = 2'b00;
   logic [DW-1:0] q_l[$];
   logic [DW-1:0] q_r[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors < 30)
            $display("FAIL %s t=%0d: got %0h expected %0h", nm, t, act, exp);
      end
   endtask

   function automatic logic [63:0] exp_frame(input logic [DW-1:0] l,
                                             input logic [DW-1:0] r);
      logic [63:0] e;
      e = '0;
      for (int p = 1; p <= DW; p++) begin
         e[p]      = l[DW-p];
         e[32 + p] = r[DW-p];
      end
      return e;
   endfunction

   task automatic cyc();
      bit acc;
      acc = bus.tx_valid && bus.tx_ready;
      if (acc) begin
         acc_cnt++;
         q_l.push_back(bus.tx_data_l);
         q_r.push_back(bus.tx_data_r);
      end
      @(posedge clk);
      t = reset ? 0 : t + 1;
      @(negedge clk);
      if (acc) begin
         if (stream_on != 0) begin
            next_val++;
            bus.tx_data_l = 24'hA00000 + 24'(next_val);
            bus.tx_data_r = 24'h05FFF0 - 24'(next_val);
         end else begin
            bus.tx_valid = 1'b0;
         end
         chk("ready_after_accept", 64'(bus.tx_ready), 64'd0);
      end
      if (!reset) begin
         if (underrun) begin
            ur_cnt++;
            ur_t = t;
         end
         chk("clk_shape", {62'd0, sclk, lrck},
             {62'd0, (t % 4) >= 2, ((t / 4) % 64) >= 32});
         if ((t % 4) != 0)
            chk("edge_align", {62'd0, lrck, sdata}, {62'd0, prev});
         if (stream_on != 0)
            chk("stream_ready", 64'(bus.tx_ready), 64'((t % FRAME) == 0));
      end
      prev = {lrck, sdata};
   endtask

   task automatic capture(output logic [63:0] bits, output logic [63:0] lr);
      bits = '0;
      lr = '0;
      for (int i = 0; i < FRAME; i++) begin
         if ((t % 4) == 2) begin
            bits[(t / 4) % 64] = sdata;
            lr[(t / 4) % 64]   = lrck;
         end
         cyc();
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      bus.tx_valid = 1'b0;
      repeat (n) begin
         cyc();
         chk("reset_outputs", {59'd0, sclk, lrck, sdata, underrun, bus.tx_ready},
             64'd0);
      end
      reset = 1'b0;
      #1;
      chk("ready_after_reset", 64'(bus.tx_ready), 64'd1);
   endtask

   vec_t tbl[14];
   logic [63:0] bits, lr;
   logic [63:0] lr_exp;
   int ur0, acc0;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{0, 1'b0, 1'b0};
      tbl[1]  = '{1, 1'b1, 1'b0};
      tbl[2]  = '{2, 1'b0, 1'b0};
      tbl[3]  = '{23, 1'b0, 1'b0};
      tbl[4]  = '{24, 1'b1, 1'b0};
      tbl[5]  = '{25, 1'b0, 1'b0};
      tbl[6]  = '{31, 1'b0, 1'b0};
      tbl[7]  = '{32, 1'b0, 1'b1};
      tbl[8]  = '{33, 1'b0, 1'b1};
      tbl[9]  = '{34, 1'b1, 1'b1};
      tbl[10] = '{55, 1'b1, 1'b1};
      tbl[11] = '{56, 1'b0, 1'b1};
      tbl[12] = '{57, 1'b0, 1'b1};
      tbl[13] = '{63, 1'b0, 1'b1};
      lr_exp = {32'hFFFFFFFF, 32'h00000000};

      reset = 1'b1;
      bus.tx_valid  = 1'b0;
      bus.tx_data_l = '0;
      bus.tx_data_r = '0;
      @(negedge clk);
      do_reset(5);

      // single pair before the first load
      bus.tx_data_l = 24'h800001;
      bus.tx_data_r = 24'h7FFFFE;
      bus.tx_valid  = 1'b1;
      capture(bits, lr);
      chk("first_frame_silent", bits, 64'd0);
      chk("first_frame_no_ur", 64'(ur_cnt), 64'd0);
      chk("single_accepted", 64'(acc_cnt), 64'd1);

      capture(bits, lr);
      foreach (tbl[i]) begin
         chk($sformatf("single_sdata_p%0d", tbl[i].p),
             64'(bits[tbl[i].p]), 64'(tbl[i].sd));
         chk($sformatf("single_lrck_p%0d", tbl[i].p),
             64'(lr[tbl[i].p]), 64'(tbl[i].lr));
      end
      chk("single_frame", bits, exp_frame(24'h800001, 24'h7FFFFE));
      chk("lrck_frame", lr, lr_exp);
      chk("underrun_count", 64'(ur_cnt), 64'd1);
      chk("underrun_time", 64'(ur_t), 64'd512);

      capture(bits, lr);
      chk("underrun_frame_zero", bits, 64'd0);

      // streaming from a frame boundary
      q_l.delete();
      q_r.delete();
      ur0 = ur_cnt;
      acc0 = acc_cnt;
      stream_on = 1;
      next_val = 0;
      bus.tx_data_l = 24'hA00000;
      bus.tx_data_r = 24'h05FFF0;
      bus.tx_valid  = 1'b1;
      capture(bits, lr);
      chk("stream_frame0_zero", bits, 64'd0);
      for (int k = 0; k < 8; k++) begin
         capture(bits, lr);
         chk($sformatf("stream_frame%0d", k + 1), bits,
             exp_frame(24'hA00000 + 24'(k), 24'h05FFF0 - 24'(k)));
      end
      chk("stream_accepts", 64'(acc_cnt - acc0), 64'd9);
      chk("stream_no_underrun", 64'(ur_cnt - ur0), 64'd0);
      stream_on = 0;

      // mid-frame reset with a full buffer
      bus.tx_data_l = 24'h5A5A5A;
      bus.tx_data_r = 24'hC3C3C3;
      bus.tx_valid  = 1'b1;
      for (int i = 0; i < 40; i++) cyc();
      chk("midreset_position", 64'((t / 4) % 64), 64'd10);
      chk("midreset_buffer_full", 64'(bus.tx_ready), 64'd0);
      do_reset(3);
      ur0 = ur_cnt;
      capture(bits, lr);
      chk("after_reset_silent", bits, 64'd0);
      chk("after_reset_ur", 64'(ur_cnt - ur0), 64'd1);
      chk("after_reset_ur_time", 64'(ur_t), 64'd256);
      capture(bits, lr);
      chk("discarded_pair", bits, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
